// File: rtl/uart_rx_deframer.sv
// uart_rx_deframer: receives 8N1 frames from the UART transmitter's tx line.
// The serial input passes through a two-flop synchronizer. Each bit is sampled
// once at mid-bit. Every completed frame yields a byte plus either a one-cycle
// valid pulse or a one-cycle framing-error pulse.
module uart_rx_deframer #(
    parameter int BAUD_DIV = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] data_out,
    output logic       rx_valid,
    output logic       frame_error,
    output logic       busy
);

    localparam int          HALF      = BAUD_DIV / 2;
    localparam logic [15:0] HALF_LAST = 16'(HALF - 1);
    localparam logic [15:0] BIT_LAST  = 16'(BAUD_DIV - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        RECOVER
    } state_t;

    state_t      state;
    logic        rx_meta;
    logic        rx_s;
    logic [15:0] baud_cnt;
    logic [2:0]  bit_cnt;
    logic [7:0]  shift_reg;

    // Two-flop synchronizer; both flops reset to the idle (high) line level
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    // Frame FSM: start detection, mid-bit sampling, stop check and break recovery
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            baud_cnt    <= 16'd0;
            bit_cnt     <= 3'd0;
            shift_reg   <= 8'h00;
            data_out    <= 8'h00;
            rx_valid    <= 1'b0;
            frame_error <= 1'b0;
            busy        <= 1'b0;
        end else begin
            rx_valid    <= 1'b0;
            frame_error <= 1'b0;
            case (state)
                IDLE: begin
                    busy <= 1'b0;
                    if (!rx_s) begin
                        state    <= START;
                        baud_cnt <= 16'd0;
                        busy     <= 1'b1;
                    end
                end
                START: begin
                    if (baud_cnt == HALF_LAST) begin
                        baud_cnt <= 16'd0;
                        if (!rx_s) begin
                            state   <= DATA;
                            bit_cnt <= 3'd0;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                DATA: begin
                    if (baud_cnt == BIT_LAST) begin
                        baud_cnt  <= 16'd0;
                        shift_reg <= {rx_s, shift_reg[7:1]};
                        bit_cnt   <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            state <= STOP;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                STOP: begin
                    if (baud_cnt == BIT_LAST) begin
                        baud_cnt <= 16'd0;
                        if (rx_s) begin
                            data_out <= shift_reg;
                            rx_valid <= 1'b1;
                            state    <= IDLE;
                            busy     <= 1'b0;
                        end else begin
                            frame_error <= 1'b1;
                            state       <= RECOVER;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                RECOVER: begin
                    busy <= 1'b1;
                    if (rx_s) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_deframer.sv
// tb_uart_rx_deframer: drives 8N1 frames into uart_rx_deframer and compares
// every reported frame (cycle, kind, byte) against a frame-level model.
module tb_uart_rx_deframer;

    localparam int BAUD_DIV = 4;
    localparam int HALF     = BAUD_DIV / 2;
    localparam int LATENCY  = 2 + HALF + 9 * BAUD_DIV + 1;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx;
    logic [7:0] data_out;
    logic       rx_valid;
    logic       frame_error;
    logic       busy;

    typedef struct {
        int         cyc;
        logic       err;
        logic [7:0] data;
    } ev_t;

    ev_t        exp_q[$];
    ev_t        obs_q[$];
    logic [7:0] last_good;
    int         cyc      = 0;
    int         checks   = 0;
    int         failures = 0;

    uart_rx_deframer #(.BAUD_DIV(BAUD_DIV)) dut (
        .clk         (clk),
        .reset       (reset),
        .rx          (rx),
        .data_out    (data_out),
        .rx_valid    (rx_valid),
        .frame_error (frame_error),
        .busy        (busy)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Count rising edges so events can be time-stamped
    always @(posedge clk) cyc <= cyc + 1;

    // Record every output pulse and check that valid and error never coincide
    always @(negedge clk) begin
        if (rx_valid || frame_error) begin
            ev_t o;
            checks++;
            assert (!(rx_valid && frame_error)) else begin
                failures++;
                $error("[TB] FAIL exclusive: observed rx_valid=%b frame_error=%b expected not both", rx_valid, frame_error);
            end
            o.cyc  = cyc;
            o.err  = frame_error;
            o.data = data_out;
            obs_q.push_back(o);
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            failures++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, got, want);
        end
    endtask

    task automatic drive_bit(input logic v);
        rx = v;
        tick(BAUD_DIV);
    endtask

    // Drive one frame and predict its outcome: a good stop bit updates the byte,
    // a bad one reports an error while the last good byte stays visible
    task automatic apply_stimulus(input logic [7:0] b, input logic stop_ok,
                                  input int low_hold, input int gap);
        ev_t e;
        e.cyc = cyc + LATENCY;
        e.err = !stop_ok;
        if (stop_ok) last_good = b;
        e.data = last_good;
        exp_q.push_back(e);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop_ok);
        if (!stop_ok) begin
            rx = 1'b0;
            tick(low_hold);
        end
        rx = 1'b1;
        tick(gap);
    endtask

    // Let pending frames resolve, then match observed pulses against predictions
    task automatic check_output(input string tag);
        int n;
        tick(LATENCY);
        check_val({tag, "_count"}, obs_q.size(), exp_q.size());
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int k = 0; k < n; k++) begin
            ev_t o;
            ev_t e;
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            check_val($sformatf("%s_cyc%0d", tag, k), o.cyc, e.cyc);
            check_val($sformatf("%s_err%0d", tag, k), {31'd0, o.err}, {31'd0, e.err});
            check_val($sformatf("%s_data%0d", tag, k), {24'd0, o.data}, {24'd0, e.data});
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    initial begin
        int busy_cnt;
        reset     = 1'b1;
        rx        = 1'b1;
        last_good = 8'h00;
        tick(3);
        @(negedge clk);
        check_val("rst_data", {24'd0, data_out}, 32'h0);
        check_val("rst_valid", {31'd0, rx_valid}, 32'h0);
        check_val("rst_ferr", {31'd0, frame_error}, 32'h0);
        check_val("rst_busy", {31'd0, busy}, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        tick(3);

        $display("[TB] single frame");
        apply_stimulus(8'hA5, 1'b1, 0, 5);
        check_output("single");

        $display("[TB] back-to-back frames");
        apply_stimulus(8'h00, 1'b1, 0, 0);
        apply_stimulus(8'hFF, 1'b1, 0, 5);
        check_output("b2b");

        $display("[TB] glitch rejection");
        rx = 1'b0;
        tick(1);
        rx = 1'b1;
        busy_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
        end
        check_val("glitch_busy", busy_cnt, HALF);
        @(posedge clk);
        #1;
        apply_stimulus(8'h3C, 1'b1, 0, 5);
        check_output("glitch");

        $display("[TB] framing error and recovery");
        apply_stimulus(8'h5A, 1'b0, 20, 5);
        apply_stimulus(8'h81, 1'b1, 0, 5);
        check_output("ferr");

        $display("[TB] reset mid-frame");
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(logic'((8'hF0 >> i) & 8'h01));
        check_val("mid_busy", {31'd0, busy}, 32'h1);
        reset = 1'b1;
        tick(2);
        check_val("mid_rst_data", {24'd0, data_out}, 32'h0);
        check_val("mid_rst_valid", {31'd0, rx_valid}, 32'h0);
        check_val("mid_rst_ferr", {31'd0, frame_error}, 32'h0);
        check_val("mid_rst_busy", {31'd0, busy}, 32'h0);
        rx    = 1'b1;
        reset = 1'b0;
        last_good = 8'h00;
        tick(5);
        apply_stimulus(8'h0F, 1'b1, 0, 5);
        check_output("reset");

        $display("[TB] loopback 0x00-0xFF");
        for (int i = 0; i < 256; i++) apply_stimulus(8'(i), 1'b1, 0, 0);
        tick(2);
        check_output("loop");

        $display("[TB] randomized frames");
        for (int i = 0; i < 40; i++) begin
            logic [7:0] b;
            logic       ok;
            b  = 8'($urandom);
            ok = ($urandom_range(0, 4) != 0);
            if (ok) apply_stimulus(b, 1'b1, 0, $urandom_range(0, 6));
            else    apply_stimulus(b, 1'b0, $urandom_range(0, 10), $urandom_range(1, 6));
        end
        check_output("random");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
